// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the issue/hazard controller
// Contents: fwd_sel_t operand source encoding, stage_t pipeline stage record,
// REG_ZERO, STAGE_BUBBLE, and the per-stage match and forwardability helpers.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       writeback;
        logic       is_load;
    } stage_t;

    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam stage_t     STAGE_BUBBLE = '0;

    // A stage produces the operand the decoder wants. x0 is hardwired, so
    // a write to it never counts as a producer.
    function automatic logic rd_match(
        input logic       valid,
        input logic       writeback,
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic       uses
    );
        return valid && writeback && (rd == rs) && (rs != REG_ZERO) && uses;
    endfunction

    // Load data only exists once the instruction reaches WB.
    function automatic logic fwd_ok(input logic is_load, input logic load_data_ready);
        return !is_load || load_data_ready;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decoder-to-controller issue handshake
// Signals: dec_valid plus source/destination fields and flags from the
// decoder; issue_ready returned by the controller.
// master: decoder side. slave: hazard controller side.
interface pipe_hazard_ctrl_if;
    logic       dec_valid;
    logic [4:0] dec_rs1_addr;
    logic [4:0] dec_rs2_addr;
    logic       dec_uses_rs1;
    logic       dec_uses_rs2;
    logic [4:0] dec_rd_addr;
    logic       dec_writeback;
    logic       dec_is_load;
    logic       issue_ready;

    modport master (
        output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_uses_rs1, dec_uses_rs2,
        output dec_rd_addr, dec_writeback, dec_is_load,
        input  issue_ready
    );

    modport slave (
        input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_uses_rs1, dec_uses_rs2,
        input  dec_rd_addr, dec_writeback, dec_is_load,
        output issue_ready
    );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// rtl/pipe_hazard_ctrl_fwd_select.sv - one operand's forwarding select and load-use detect
// Ports: rs_addr/uses_rs (decoder operand), ex/mem/wb_stage (in-flight state),
// sel (youngest forwardable producer), hazard (producer is a load not yet in WB).
module fwd_select
    import pipe_pkg::*;
(
    input  logic [4:0] rs_addr,
    input  logic       uses_rs,
    input  stage_t     ex_stage,
    input  stage_t     mem_stage,
    input  stage_t     wb_stage,
    output fwd_sel_t   sel,
    output logic       hazard
);

    logic m_ex;
    logic m_mem;
    logic m_wb;

    assign m_ex  = rd_match(ex_stage.valid,  ex_stage.writeback,  ex_stage.rd,  rs_addr, uses_rs);
    assign m_mem = rd_match(mem_stage.valid, mem_stage.writeback, mem_stage.rd, rs_addr, uses_rs);
    assign m_wb  = rd_match(wb_stage.valid,  wb_stage.writeback,  wb_stage.rd,  rs_addr, uses_rs);

    assign hazard = (m_ex && ex_stage.is_load) || (m_mem && mem_stage.is_load);

    // Youngest producer wins; a load in EX/MEM is skipped here because the
    // hazard path already holds the instruction until the load reaches WB.
    always_comb begin
        sel = FWD_RF;
        if (m_ex && fwd_ok(ex_stage.is_load, 1'b0)) begin
            sel = FWD_EX;
        end else if (m_mem && fwd_ok(mem_stage.is_load, 1'b0)) begin
            sel = FWD_MEM;
        end else if (m_wb && fwd_ok(wb_stage.is_load, 1'b1)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - issue and hazard controller for the pipelined core
// Ports: clk, rst (sync, active-high); dec (decoder handshake, slave side);
// flush (taken branch from EX); rs1/rs2_fwd_sel (operand sources);
// ex/mem/wb_valid (stage occupancy); wb_rd_addr/wb_we (regfile write);
// stall_count/flush_count (saturating event counters).
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  dec,
    input  logic               flush,
    output logic [1:0]         rs1_fwd_sel,
    output logic [1:0]         rs2_fwd_sel,
    output logic               ex_valid,
    output logic               mem_valid,
    output logic               wb_valid,
    output logic [4:0]         wb_rd_addr,
    output logic               wb_we,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count
);

    stage_t   ex_q;
    stage_t   mem_q;
    stage_t   wb_q;
    stage_t   dec_stage;
    fwd_sel_t sel1;
    fwd_sel_t sel2;
    logic     haz1;
    logic     haz2;
    logic     hazard;
    logic     accept;

    fwd_select u_rs1 (
        .rs_addr   (dec.dec_rs1_addr),
        .uses_rs   (dec.dec_uses_rs1),
        .ex_stage  (ex_q),
        .mem_stage (mem_q),
        .wb_stage  (wb_q),
        .sel       (sel1),
        .hazard    (haz1)
    );

    fwd_select u_rs2 (
        .rs_addr   (dec.dec_rs2_addr),
        .uses_rs   (dec.dec_uses_rs2),
        .ex_stage  (ex_q),
        .mem_stage (mem_q),
        .wb_stage  (wb_q),
        .sel       (sel2),
        .hazard    (haz2)
    );

    assign hazard          = haz1 || haz2;
    assign dec.issue_ready = !rst && !hazard && !flush;
    assign accept          = dec.dec_valid && dec.issue_ready;

    assign dec_stage = '{
        valid:     1'b1,
        rd:        dec.dec_rd_addr,
        writeback: dec.dec_writeback,
        is_load:   dec.dec_is_load
    };

    // While reset is held the stage state is stale, so report regfile sources.
    assign rs1_fwd_sel = rst ? FWD_RF : sel1;
    assign rs2_fwd_sel = rst ? FWD_RF : sel2;

    assign ex_valid   = ex_q.valid;
    assign mem_valid  = mem_q.valid;
    assign wb_valid   = wb_q.valid;
    assign wb_rd_addr = wb_q.rd;
    assign wb_we      = wb_q.valid && wb_q.writeback && (wb_q.rd != REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= STAGE_BUBBLE;
            mem_q       <= STAGE_BUBBLE;
            wb_q        <= STAGE_BUBBLE;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            ex_q  <= accept ? dec_stage : STAGE_BUBBLE;
            mem_q <= ex_q;
            wb_q  <= mem_q;

            // A flushed cycle is charged to the branch, not to the stall.
            if (dec.dec_valid && hazard && !flush && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (flush && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [1:0]       rs1_fwd_sel;
    logic [1:0]       rs2_fwd_sel;
    logic             ex_valid;
    logic             mem_valid;
    logic             wb_valid;
    logic [4:0]       wb_rd_addr;
    logic             wb_we;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    pipe_hazard_ctrl_if dec_bus ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .dec         (dec_bus),
        .flush       (flush),
        .rs1_fwd_sel (rs1_fwd_sel),
        .rs2_fwd_sel (rs2_fwd_sel),
        .ex_valid    (ex_valid),
        .mem_valid   (mem_valid),
        .wb_valid    (wb_valid),
        .wb_rd_addr  (wb_rd_addr),
        .wb_we       (wb_we),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [4:0] rd;
        logic       we;
    } wb_exp_t;

    wb_exp_t          sb[$];
    int               cycle  = 0;
    int               total  = 0;
    int               passed = 0;
    int               fails  = 0;
    logic [CNT_W-1:0] exp_stall = '0;
    logic [CNT_W-1:0] exp_flush = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ins(input logic v, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                           input logic wbk, input logic ld);
        dec_bus.dec_valid     = v;
        dec_bus.dec_rs1_addr  = rs1;
        dec_bus.dec_uses_rs1  = u1;
        dec_bus.dec_rs2_addr  = rs2;
        dec_bus.dec_uses_rs2  = u2;
        dec_bus.dec_rd_addr   = rd;
        dec_bus.dec_writeback = wbk;
        dec_bus.dec_is_load   = ld;
    endtask

    // One clock: check combinational outputs, push accepted instructions to
    // the scoreboard, clock, then compare stage occupancy, WB and counters.
    task automatic step(input logic exp_ready, input logic [1:0] e1, input logic [1:0] e2);
        wb_exp_t e;
        logic    ex_e;
        logic    mem_e;
        #1;
        chk("issue_ready", dec_bus.issue_ready, exp_ready);
        chk("rs1_fwd_sel", rs1_fwd_sel, e1);
        chk("rs2_fwd_sel", rs2_fwd_sel, e2);
        if (!rst) begin
            if (dec_bus.dec_valid && exp_ready) begin
                e.due = cycle + 3;
                e.rd  = dec_bus.dec_rd_addr;
                e.we  = dec_bus.dec_writeback && (dec_bus.dec_rd_addr != 5'd0);
                sb.push_back(e);
            end
            if (dec_bus.dec_valid && !exp_ready && !flush && exp_stall != CNT_MAX) exp_stall++;
            if (flush && exp_flush != CNT_MAX) exp_flush++;
        end
        @(posedge clk);
        #1;
        cycle++;
        if (rst) begin
            sb.delete();
            exp_stall = '0;
            exp_flush = '0;
        end
        ex_e  = 1'b0;
        mem_e = 1'b0;
        foreach (sb[i]) begin
            if (sb[i].due == cycle + 2) ex_e = 1'b1;
            if (sb[i].due == cycle + 1) mem_e = 1'b1;
        end
        chk("ex_valid", ex_valid, ex_e);
        chk("mem_valid", mem_valid, mem_e);
        if (sb.size() > 0 && sb[0].due == cycle) begin
            chk("wb_valid", wb_valid, 1);
            chk("wb_rd_addr", wb_rd_addr, sb[0].rd);
            chk("wb_we", wb_we, sb[0].we);
            void'(sb.pop_front());
        end else begin
            chk("wb_valid_idle", wb_valid, 0);
            chk("wb_we_idle", wb_we, 0);
        end
        chk("stall_count", stall_count, exp_stall);
        chk("flush_count", flush_count, exp_flush);
    endtask

    task automatic drain(input int n);
        set_ins(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) step(1, 0, 0);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        set_ins(1, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("reset_wb_rd_addr", wb_rd_addr, 0);
        chk("reset_stall_count", stall_count, 0);
        rst = 1'b0;

        // ALU chain: addi x1; add x2,x1,x1; nop; reader of x1/x2
        set_ins(1, 0, 1, 0, 0, 1, 1, 0);  step(1, 0, 0);
        set_ins(1, 1, 1, 1, 1, 2, 1, 0);  step(1, 1, 1);
        set_ins(0, 0, 0, 0, 0, 0, 0, 0);  step(1, 0, 0);
        set_ins(1, 1, 1, 2, 1, 14, 1, 0); step(1, 3, 2);
        drain(4);

        // Load-use at distance 1: two stall cycles, then forward from WB
        set_ins(1, 0, 1, 0, 0, 3, 1, 1);  step(1, 0, 0);
        set_ins(1, 3, 1, 0, 0, 4, 1, 0);  step(0, 0, 0); step(0, 0, 0); step(1, 3, 0);
        chk("stall_after_load_use", stall_count, 2);
        // Load-use at distance 2: one stall cycle
        set_ins(1, 0, 1, 0, 0, 3, 1, 1);  step(1, 0, 0);
        set_ins(0, 0, 0, 0, 0, 0, 0, 0);  step(1, 0, 0);
        set_ins(1, 3, 1, 0, 0, 11, 1, 0); step(0, 0, 0); step(1, 3, 0);
        // Hazard raised by rs2 alone
        set_ins(1, 0, 0, 0, 0, 9, 1, 1);  step(1, 0, 0);
        set_ins(1, 1, 1, 9, 1, 12, 1, 0); step(0, 0, 0); step(0, 0, 0); step(1, 0, 3);
        chk("stall_after_rs2", stall_count, 5);
        drain(4);

        // x0 is never a producer and never written
        set_ins(1, 0, 1, 0, 0, 0, 1, 0);  step(1, 0, 0);
        set_ins(1, 0, 1, 0, 1, 13, 1, 0); step(1, 0, 0);
        drain(4);

        // Two writers of x5, youngest wins; then MEM beats WB for x8
        set_ins(1, 0, 0, 0, 0, 5, 1, 0);  step(1, 0, 0);
        set_ins(1, 0, 0, 0, 0, 5, 1, 0);  step(1, 0, 0);
        set_ins(1, 5, 1, 5, 1, 10, 1, 0); step(1, 1, 1);
        set_ins(1, 0, 0, 0, 0, 8, 1, 0);  step(1, 0, 0);
        set_ins(1, 0, 0, 0, 0, 8, 1, 0);  step(1, 0, 0);
        set_ins(0, 0, 0, 0, 0, 0, 0, 0);  step(1, 0, 0);
        set_ins(1, 8, 0, 8, 1, 15, 1, 0); step(1, 0, 2);
        drain(4);

        // Flush while a load-use hazard is pending, then flush with no instruction
        set_ins(1, 0, 1, 0, 0, 3, 1, 1);  step(1, 0, 0);
        set_ins(1, 3, 1, 0, 0, 4, 1, 0);
        flush = 1'b1;                     step(0, 0, 0);
        chk("flush_count_one", flush_count, 1);
        chk("stall_unchanged", stall_count, 5);
        set_ins(0, 0, 0, 0, 0, 0, 0, 0);  step(0, 0, 0);
        flush = 1'b0;
        drain(4);

        // Self-dependent load held for long enough to saturate stall_count
        set_ins(1, 3, 1, 0, 0, 3, 1, 1);
        for (int i = 0; i < 400; i++) begin
            step((i % 3) == 0, ((i % 3) == 0 && i > 0) ? 2'd3 : 2'd0, 0);
        end
        chk("stall_saturated", stall_count, CNT_MAX);
        drain(4);

        // Reset mid-stream drops in-flight writers
        set_ins(1, 0, 0, 0, 0, 1, 1, 0);  step(1, 0, 0);
        set_ins(1, 0, 0, 0, 0, 2, 1, 0);  step(1, 0, 0);
        rst = 1'b1;
        set_ins(1, 1, 1, 2, 1, 3, 1, 0);  step(0, 0, 0);
        chk("midrst_stall_count", stall_count, 0);
        chk("midrst_flush_count", flush_count, 0);
        rst = 1'b0;
        step(1, 0, 0);
        drain(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
